stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 Parameter WIDTH, default 16, data word width.
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, minimum 2.
REQ-003 clock  input  1  system clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 push  input  1  push command, sampled each rising edge.
REQ-006 pop  input  1  pop command, sampled each rising edge.
REQ-007 src_sel  input  1  push source: 0 = data_in (memory/immediate path), 1 = alu_in (ALU result path).
REQ-008 data_in  input  WIDTH  push operand from memory/immediate path.
REQ-009 alu_in  input  WIDTH  push operand from ALU result.
REQ-010 top  output  WIDTH  registered top-of-stack value; 0 when empty.
REQ-011 count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-012 empty / full  output  1 each  occupancy flags, decoded from state.
REQ-013 overflow / underflow  output  1 each  error flags.

Function
REQ-014 The occupancy FSM SHALL have states EMPTY, MID, FULL; the FSM SHALL be in EMPTY iff count==0, in FULL iff count==DEPTH, and in MID otherwise.
REQ-015 Push alone, not FULL: store the selected operand, count+1, top = operand in the next cycle (latency 1).
REQ-016 Pop alone, not EMPTY: count-1, top = previous entry in the next cycle, or 0 if the stack becomes empty.
REQ-017 Push and pop in the same cycle, not EMPTY: replace the top entry with the selected operand; count is unchanged; top = operand in the next cycle.
REQ-018 Push and pop in the same cycle while EMPTY: no state change; underflow asserts.
REQ-019 Push while FULL, without pop: no state change; stored data is preserved; overflow asserts.
REQ-020 Pop while EMPTY, without push: no state change; top stays 0; underflow asserts.
REQ-021 Neither push nor pop: all state holds.
REQ-022 The operand SHALL be chosen by src_sel in the same cycle that push is sampled; no operand is latched in advance.
REQ-023 Entries SHALL be zero-extended WIDTH-bit words; the block performs no arithmetic on data.
REQ-024 The stack pointer SHALL never wrap; count saturates at 0 and DEPTH.
REQ-025 Transitions: EMPTY->MID on push; MID->FULL on push at count==DEPTH-1; FULL->MID on pop; MID->EMPTY on pop at count==1. A simultaneous push and pop leaves the state unchanged.

Reset
REQ-026 reset SHALL force state EMPTY, count=0, top=0, overflow=0, underflow=0; storage contents need not be cleared.
REQ-027 reset has priority over a push or pop in the same cycle, and that command is discarded.

Configuration
REQ-028 With STACK_ERR_STICKY_EN defined, overflow and underflow SHALL latch at 1 until reset.
REQ-029 Without STACK_ERR_STICKY_EN, overflow and underflow SHALL each be a one-cycle pulse in the cycle after the offending command.

Structure
REQ-030 Package stack_pkg SHALL hold the default WIDTH/DEPTH constants, the src_sel encodings SRC_DATA=0/SRC_ALU=1, and the FSM state typedef.
REQ-031 Storage SHALL be sub-module stack_ram: synchronous write, asynchronous read, DEPTH x WIDTH.
REQ-032 The FSM, pointer, flags and top register SHALL live in stack_unit.

Verification
REQ-033 Reset, then push data_in=0x0005 with src_sel=0 -> next cycle top=0x0005, count=1, empty=0.
REQ-034 Push 0x0003, then push alu_in=0x0008 with src_sel=1, then pop -> top=0x0008 after the second push, 0x0003 after the pop, count=1.
REQ-035 Fill to DEPTH=16 with values 1..16, then push 0xFFFF -> full=1, overflow=1, top=16, count=16.
REQ-036 From empty, pop; separately, push and pop together -> underflow=1 each time, count=0, top=0; the error is sticky only when STACK_ERR_STICKY_EN is defined.
REQ-037 With stack 1,2 (top=2), push and pop together with data_in=0x0009 -> top=0x0009, count=2; one further pop -> top=1.
REQ-038 Assert reset during a push at count=4 -> count=0, top=0, state EMPTY, flags clear.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared constants, push-source encodings and occupancy FSM state type for the stack unit.
package stack_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 16;

  localparam logic SRC_DATA = 1'b0;
  localparam logic SRC_ALU  = 1'b1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MID   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/stack_unit_if.sv
// Command/status bundle of the stack unit; master issues push/pop commands, slave is the stack.
interface stack_unit_if #(
  parameter int WIDTH = stack_pkg::DEFAULT_WIDTH,
  parameter int DEPTH = stack_pkg::DEFAULT_DEPTH
);
  import stack_pkg::*;

  // There is no valid/ready pair: push and pop are commands sampled on every rising
  // clock edge and always accepted; illegal commands are reported via overflow/underflow.
  logic                       push;
  logic                       pop;
  logic                       src_sel;
  logic [WIDTH-1:0]           data_in;
  logic [WIDTH-1:0]           alu_in;
  logic [WIDTH-1:0]           top;
  logic [$clog2(DEPTH):0]     count;
  logic                       empty;
  logic                       full;
  logic                       overflow;
  logic                       underflow;
  state_t                     state;

  modport master (
    output push, pop, src_sel, data_in, alu_in,
    input  top, count, empty, full, overflow, underflow, state
  );

  modport slave (
    input  push, pop, src_sel, data_in, alu_in,
    output top, count, empty, full, overflow, underflow, state
  );

endinterface

// File: rtl/stack_ram.sv
// DEPTH x WIDTH stack storage: synchronous write port, asynchronous read port.
module stack_ram
  import stack_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// Hardware LIFO stack with registered top-of-stack and occupancy FSM.
// Define STACK_ERR_STICKY_EN to latch overflow/underflow until reset instead of pulsing them.
module stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic         clock,
  input  logic         reset,
  stack_unit_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic             ovf_q, ovf_d, ovf_hit;
  logic             unf_q, unf_d, unf_hit;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    below_idx;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] rdata;

  assign operand   = (bus.src_sel == SRC_ALU) ? bus.alu_in : bus.data_in;
  // Index arithmetic wraps within AW bits, which is exact for every count where it is used.
  assign top_idx   = count_q[AW-1:0] - AW'(1);
  assign below_idx = count_q[AW-1:0] - AW'(2);

  stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (waddr),
    .wdata (operand),
    .raddr (below_idx),
    .rdata (rdata)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    top_d   = top_q;
    we      = 1'b0;
    waddr   = count_q[AW-1:0];
    ovf_hit = 1'b0;
    unf_hit = 1'b0;
    case ({bus.push, bus.pop})
      2'b11: begin
        if (state_q == EMPTY) begin
          unf_hit = 1'b1;
        end else begin
          we    = 1'b1;
          waddr = top_idx;
          top_d = operand;
        end
      end
      2'b10: begin
        if (state_q == FULL) begin
          ovf_hit = 1'b1;
        end else begin
          we      = 1'b1;
          count_d = count_q + CW'(1);
          top_d   = operand;
          state_d = (count_q == CW'(DEPTH - 1)) ? FULL : MID;
        end
      end
      2'b01: begin
        if (state_q == EMPTY) begin
          unf_hit = 1'b1;
        end else begin
          count_d = count_q - CW'(1);
          top_d   = (count_q == CW'(1)) ? '0 : rdata;
          state_d = (count_q == CW'(1)) ? EMPTY : MID;
        end
      end
      default: ;
    endcase
`ifdef STACK_ERR_STICKY_EN
    ovf_d = ovf_q | ovf_hit;
    unf_d = unf_q | unf_hit;
`else
    ovf_d = ovf_hit;
    unf_d = unf_hit;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      count_q <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.top       = top_q;
  assign bus.count     = count_q;
  assign bus.empty     = (state_q == EMPTY);
  assign bus.full      = (state_q == FULL);
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed and random bench for stack_unit: queue-based reference stack feeds an expected-top scoreboard.
module tb_stack_unit;
  import stack_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;

`ifdef STACK_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  stack_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] model_q[$];
  logic             ovf_m = 1'b0;
  logic             unf_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic compare_outputs(input string tag);
    logic [WIDTH-1:0] exp_top;
    int               n;
    state_t           exp_state;
    n = model_q.size();
    exp_state = (n == 0) ? EMPTY : ((n == DEPTH) ? FULL : MID);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_scoreboard: observed empty queue expected an entry", tag);
    end else begin
      exp_top = exp_q.pop_front();
      check({tag, "_top"}, 32'(bus.top), 32'(exp_top));
    end
    check({tag, "_count"},     32'(bus.count),     32'(n));
    check({tag, "_empty"},     32'(bus.empty),     32'(n == 0));
    check({tag, "_full"},      32'(bus.full),      32'(n == DEPTH));
    check({tag, "_overflow"},  32'(bus.overflow),  32'(ovf_m));
    check({tag, "_underflow"}, 32'(bus.underflow), 32'(unf_m));
    check({tag, "_state"},     32'(bus.state),     32'(exp_state));
  endtask

  // Drives one command for one clock, advances the reference stack, then compares.
  task automatic step(input string tag, input logic p, input logic q, input logic s,
                      input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] a);
    logic [WIDTH-1:0] opnd;
    logic             ovf, unf;
    bus.push    = p;
    bus.pop     = q;
    bus.src_sel = s;
    bus.data_in = d;
    bus.alu_in  = a;
    opnd = s ? a : d;
    ovf  = 1'b0;
    unf  = 1'b0;
    if (p && q) begin
      if (model_q.size() == 0) unf = 1'b1;
      else model_q[model_q.size() - 1] = opnd;
    end else if (p) begin
      if (model_q.size() == DEPTH) ovf = 1'b1;
      else model_q.push_back(opnd);
    end else if (q) begin
      if (model_q.size() == 0) unf = 1'b1;
      else void'(model_q.pop_back());
    end
    ovf_m = STICKY ? (ovf_m | ovf) : ovf;
    unf_m = STICKY ? (unf_m | unf) : unf;
    exp_q.push_back((model_q.size() == 0) ? '0 : model_q[model_q.size() - 1]);
    @(posedge clock);
    #1;
    compare_outputs(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, WIDTH'($urandom_range(0, 16'hFFFF)), WIDTH'($urandom_range(0, 16'hFFFF)));
  endtask

  task automatic push_val(input string tag, input logic s, input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] junk;
    junk = WIDTH'($urandom_range(0, 16'hFFFF));
    if (s) step(tag, 1'b1, 1'b0, 1'b1, junk, v);
    else   step(tag, 1'b1, 1'b0, 1'b0, v, junk);
  endtask

  task automatic pop_one(input string tag);
    step(tag, 1'b0, 1'b1, 1'b0, WIDTH'($urandom_range(0, 16'hFFFF)), WIDTH'($urandom_range(0, 16'hFFFF)));
  endtask

  task automatic do_reset(input string tag, input logic with_push);
    reset       = 1'b1;
    bus.push    = with_push;
    bus.pop     = 1'b0;
    bus.src_sel = SRC_DATA;
    bus.data_in = 16'h00AA;
    @(posedge clock);
    #1;
    reset    = 1'b0;
    bus.push = 1'b0;
    model_q.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    exp_q.push_back('0);
    compare_outputs(tag);
  endtask

  initial begin
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.src_sel = SRC_DATA;
    bus.data_in = '0;
    bus.alu_in  = '0;

    do_reset("reset", 1'b0);

    push_val("req033_push", SRC_DATA, 16'h0005);
    check("req033_top_const", 32'(bus.top), 32'h0005);
    check("req033_count_const", 32'(bus.count), 32'd1);

    do_reset("rst034", 1'b0);
    push_val("req034_push3", SRC_DATA, 16'h0003);
    push_val("req034_push_alu", SRC_ALU, 16'h0008);
    check("req034_top_alu_const", 32'(bus.top), 32'h0008);
    pop_one("req034_pop");
    check("req034_top_pop_const", 32'(bus.top), 32'h0003);
    check("req034_count_const", 32'(bus.count), 32'd1);

    do_reset("rst036", 1'b0);
    pop_one("req036_pop_empty");
    check("req036_unf_const", 32'(bus.underflow), 32'd1);
    idle("req036_idle1");
    step("req036_pushpop_empty", 1'b1, 1'b1, SRC_DATA, 16'h0077, 16'h0066);
    check("req036_top_const", 32'(bus.top), 32'd0);
    idle("req036_idle2");

    do_reset("rst037", 1'b0);
    push_val("req037_push1", SRC_DATA, 16'h0001);
    push_val("req037_push2", SRC_ALU, 16'h0002);
    step("req037_replace", 1'b1, 1'b1, SRC_DATA, 16'h0009, 16'h00EE);
    check("req037_top_const", 32'(bus.top), 32'h0009);
    pop_one("req037_pop");
    check("req037_top_pop_const", 32'(bus.top), 32'h0001);

    do_reset("rst035", 1'b0);
    for (int i = 1; i <= DEPTH; i++) push_val("req035_fill", 1'($urandom_range(0, 1)), WIDTH'(i));
    push_val("req035_push_full", SRC_DATA, 16'hFFFF);
    check("req035_top_const", 32'(bus.top), 32'd16);
    check("req035_ovf_const", 32'(bus.overflow), 32'd1);
    idle("req035_idle");
    step("req035_replace_full", 1'b1, 1'b1, SRC_ALU, 16'h1111, 16'h4242);
    for (int i = 0; i < DEPTH; i++) pop_one("req035_drain");
    pop_one("req035_pop_empty");

    do_reset("rst038", 1'b0);
    pop_one("req038_pre_unf");
    for (int i = 0; i < 4; i++) push_val("req038_push", SRC_DATA, WIDTH'($urandom_range(0, 16'hFFFF)));
    do_reset("req038_reset_push", 1'b1);
    check("req038_count_const", 32'(bus.count), 32'd0);

    for (int i = 0; i < 120; i++) begin
      logic p, q;
      p = ($urandom_range(0, 99) < 60);
      q = ($urandom_range(0, 99) < 35);
      step("rand", p, q, 1'($urandom_range(0, 1)),
           WIDTH'($urandom_range(0, 16'hFFFF)), WIDTH'($urandom_range(0, 16'hFFFF)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
